// File: rtl/haar_pkg.sv
// haar_pkg: frame geometry, word width and FSM encoding shared by the integral-image and classifier stages
package haar_pkg;
  localparam int IMG_W_DEF = 20;
  localparam int IMG_H_DEF = 20;
  localparam int II_W_DEF  = 16;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} ii_state_t;
endpackage

// File: rtl/ii_ram.sv
// ii_ram: integral image storage with one write port, a registered bounds-checked read port and a combinational read of the word above the write position
module ii_ram import haar_pkg::*; #(
  parameter int IMG_WIDTH  = IMG_W_DEF,
  parameter int IMG_HEIGHT = IMG_H_DEF,
  parameter int II_W       = II_W_DEF,
  parameter int CW         = $clog2(IMG_WIDTH),
  parameter int RW         = $clog2(IMG_HEIGHT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [CW-1:0]   wr_col,
  input  logic [RW-1:0]   wr_row,
  input  logic [II_W-1:0] wr_data,
  output logic [II_W-1:0] up_data,
  input  logic [7:0]      rd_x,
  input  logic [7:0]      rd_y,
  output logic [II_W-1:0] rd_data
);
  localparam int DEPTH = IMG_WIDTH * IMG_HEIGHT;
  localparam int AW    = $clog2(DEPTH);
  logic [II_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_addr, up_addr, rd_addr;
  logic            rd_in;
  // address generation; row 0 has no word above so up_data reads as zero there
  always_comb begin
    wr_addr = AW'(int'(wr_row) * IMG_WIDTH + int'(wr_col));
    up_addr = AW'((int'(wr_row) - 1) * IMG_WIDTH + int'(wr_col));
    rd_in   = (int'(rd_x) < IMG_WIDTH) && (int'(rd_y) < IMG_HEIGHT);
    rd_addr = rd_in ? AW'(int'(rd_y) * IMG_WIDTH + int'(rd_x)) : '0;
    up_data = (wr_row == '0) ? '0 : mem[up_addr];
  end
  // storage is never cleared; only written by accepted pixels
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end
  // registered read, zero for coordinates outside the image
  always_ff @(posedge clk) begin
    if (!reset) rd_data <= '0;
    else rd_data <= rd_in ? mem[rd_addr] : '0;
  end
endmodule

// File: rtl/integral_image_builder.sv
// integral_image_builder: accumulates a raster-order pixel stream into an integral image and holds it until the downstream stage acknowledges it
module integral_image_builder import haar_pkg::*; #(
  parameter int IMG_WIDTH  = IMG_W_DEF,
  parameter int IMG_HEIGHT = IMG_H_DEF,
  parameter int PIX_W      = 8,
  parameter int II_W       = II_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  output logic             frame_valid,
  input  logic             frame_ack,
  input  logic [7:0]       rd_x,
  input  logic [7:0]       rd_y,
  output logic [II_W-1:0]  rd_data
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  ii_state_t       state;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [II_W-1:0] row_sum, row_sum_new, up_data, wr_data;
  logic            xfer, last_col, last_row;
  // datapath: running row sum plus the column total stored one row above
  always_comb begin
    xfer        = s_valid && s_ready && reset;
    last_col    = col == CW'(IMG_WIDTH - 1);
    last_row    = row == RW'(IMG_HEIGHT - 1);
    row_sum_new = (col == '0 ? '0 : row_sum) + II_W'(s_data);
    wr_data     = row_sum_new + up_data;
  end
  // control FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      row_sum     <= '0;
      s_ready     <= 1'b1;
      frame_valid <= 1'b0;
    end else if (xfer) begin
      row_sum <= row_sum_new;
      col     <= last_col ? '0 : col + 1'b1;
      row     <= last_col ? (last_row ? '0 : row + 1'b1) : row;
      state   <= (last_col && last_row) ? DONE : ACCUM;
      if (last_col && last_row) begin
        s_ready     <= 1'b0;
        frame_valid <= 1'b1;
      end
    end else if (state == DONE && frame_ack) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      s_ready     <= 1'b1;
      frame_valid <= 1'b0;
    end
  end
  ii_ram #(
    .IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT), .II_W(II_W), .CW(CW), .RW(RW)
  ) u_ram (
    .clk(clk), .reset(reset), .we(xfer), .wr_col(col), .wr_row(row),
    .wr_data(wr_data), .up_data(up_data), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data)
  );
endmodule

// File: tb/tb_integral_image_builder.sv
// tb_integral_image_builder: randomized frames checked against a summation reference model
module tb_integral_image_builder;
  localparam int W = 20;
  localparam int H = 20;
  logic        clk = 0;
  logic        reset = 0;
  logic        s_valid = 0;
  logic        s_ready;
  logic [7:0]  s_data = 0;
  logic        frame_valid;
  logic        frame_ack = 0;
  logic [7:0]  rd_x = 0;
  logic [7:0]  rd_y = 0;
  logic [15:0] rd_data;
  int n_vec = 0;
  int n_bad = 0;
  int pix [W][H];
  int ref_ii [W][H];
  logic [15:0] rv;

  integral_image_builder dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .frame_valid(frame_valid), .frame_ack(frame_ack), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int mode);
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        pix[x][y] = mode == 0 ? 1 : mode == 1 ? x + y : mode == 2 ? 255 : int'($urandom_range(0, 255));
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++) begin
        int s = 0;
        for (int i = 0; i <= x; i++)
          for (int j = 0; j <= y; j++) s += pix[i][j];
        ref_ii[x][y] = s % 65536;
      end
  endtask

  task automatic send_frame(input bit gaps);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        if (gaps) begin
          int k = int'($urandom_range(0, 3));
          repeat (k) begin
            s_valid = 0;
            s_data = 8'($urandom);
            frame_ack = 1'($urandom);
            tick();
          end
        end
        s_valid = 1;
        s_data = 8'(pix[x][y]);
        if (x == 0 && y == 0) check("ready_first", s_ready, 1);
        if (x == W - 1 && y == H - 1) check("fv_before_last", frame_valid, 0);
        tick();
      end
    s_valid = 0;
    frame_ack = 0;
    check("fv_after_last", frame_valid, 1);
    check("ready_done", s_ready, 0);
  endtask

  task automatic read(input int x, input int y, output logic [15:0] d);
    rd_x = 8'(x);
    rd_y = 8'(y);
    tick();
    d = rd_data;
  endtask

  task automatic check_all(input string tag);
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++) begin
        read(x, y, rv);
        check(tag, rv, 32'(ref_ii[x][y]));
      end
  endtask

  task automatic ack();
    frame_ack = 1;
    tick();
    frame_ack = 0;
    check("fv_after_ack", frame_valid, 0);
    check("ready_after_ack", s_ready, 1);
  endtask

  task automatic ones_points();
    read(19, 19, rv); check("ones_19_19", rv, 400);
    read(0, 0, rv);   check("ones_0_0", rv, 1);
    read(4, 9, rv);   check("ones_4_9", rv, 50);
  endtask

  initial begin
    reset = 0;
    tick(); tick();
    check("rst_ready", s_ready, 1);
    check("rst_fv", frame_valid, 0);
    check("rst_rd", rd_data, 0);
    reset = 1;
    tick();
    fill(0);
    send_frame(0);
    ones_points();
    check_all("ones_all");
    ack();
    fill(1);
    send_frame(1);
    check_all("xy_all");
    ack();
    fill(2);
    send_frame(0);
    read(19, 19, rv); check("sat_19_19", rv, 36464);
    for (int i = 0; i < 10; i++) begin
      s_valid = 1;
      s_data = 8'($urandom);
      check("done_ready", s_ready, 0);
      check("done_fv", frame_valid, 1);
      tick();
    end
    s_valid = 0;
    check_all("done_hold");
    ack();
    fill(3);
    for (int n = 0; n < 57; n++) begin
      s_valid = 1;
      s_data = 8'($urandom);
      tick();
    end
    s_valid = 0;
    reset = 0;
    tick();
    reset = 1;
    check("midrst_fv", frame_valid, 0);
    check("midrst_ready", s_ready, 1);
    fill(0);
    send_frame(1);
    ones_points();
    check_all("midrst_all");
    read(20, 3, rv);  check("oor_x", rv, 0);
    read(3, 200, rv); check("oor_y", rv, 0);
    ack();
    fill(3);
    send_frame(1);
    check_all("rand_all");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
